iq_burst_ctrl: RTL and testbench

Burst sequencer that drives the IQ modulator's control inputs (enable, frequency step, Q phase offset, amplitude coefficient). It accepts one burst command at a time over a valid/ready handshake, ramps the amplitude up, holds for a programmed length, ramps down, then idles the modulator for a programmed gap before signalling completion. It sits between the register/command front end and the modulator instance, and is the only driver of those modulator inputs.

---
 rtl/iq_burst_pkg.sv | 30 +++
 rtl/iq_amp_ramp.sv | 38 +++
 rtl/iq_burst_ctrl.sv | 118 +++++++++++
 tb/tb_iq_burst_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/iq_burst_pkg.sv
// Shared types, default widths and saturating arithmetic for the IQ burst sequencer.
package iq_burst_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int AMP_WIDTH_DEF = 8;
  localparam int LEN_W_DEF     = 16;
  localparam int RAMP_STEP_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD      = 3'd2,
    RAMP_DOWN = 3'd3,
    GAP       = 3'd4
  } state_t;

  // min(a + b, lim); the extra carry bit keeps the sum from wrapping
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

  // max(a - b, 0)
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/iq_amp_ramp.sv
// Amplitude register with saturating ramp-up toward a target and ramp-down toward zero.
module iq_amp_ramp
  import iq_burst_pkg::*;
#(
  parameter int AMP_WIDTH = AMP_WIDTH_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 i_up,
  input  logic                 i_down,
  input  logic                 i_clear,
  input  logic [AMP_WIDTH-1:0] i_target,
  output logic [AMP_WIDTH-1:0] o_amp,
  output logic                 o_at_target,
  output logic                 o_at_zero
);

  logic [AMP_WIDTH-1:0] r_amp;
  logic [AMP_WIDTH-1:0] w_amp_up;
  logic [AMP_WIDTH-1:0] w_amp_dn;

  // Results never exceed target / fall below zero, so truncation back to AMP_WIDTH is lossless
  assign w_amp_up = AMP_WIDTH'(sat_add(32'(r_amp), 32'(RAMP_STEP), 32'(i_target)));
  assign w_amp_dn = AMP_WIDTH'(sat_sub(32'(r_amp), 32'(RAMP_STEP)));

  assign o_amp       = r_amp;
  assign o_at_target = (w_amp_up == i_target);
  assign o_at_zero   = (r_amp == '0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)       r_amp <= '0;
    else if (i_clear) r_amp <= '0;
    else if (i_up)    r_amp <= w_amp_up;
    else if (i_down)  r_amp <= w_amp_dn;
  end

endmodule

// File: rtl/iq_burst_ctrl.sv
// Burst sequencer for the IQ modulator: ramp up, hold, ramp down, idle gap, done pulse.
module iq_burst_ctrl
  import iq_burst_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AMP_WIDTH = AMP_WIDTH_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_step,
  input  logic [ADDR_W-1:0]    cmd_phase_q,
  input  logic [AMP_WIDTH-1:0] cmd_amp,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic [LEN_W-1:0]     cmd_gap,
  input  logic                 abort_in,
  output logic                 mod_en,
  output logic [ADDR_W-1:0]    mod_step,
  output logic [ADDR_W-1:0]    mod_phase_q,
  output logic [AMP_WIDTH-1:0] mod_amp,
  output logic                 busy,
  output logic                 done
);

  state_t               r_state, w_next;
  logic [AMP_WIDTH-1:0] r_target;
  logic [LEN_W-1:0]     r_len, r_gap, r_hold_cnt, r_gap_cnt;
  logic [ADDR_W-1:0]    r_mod_step, r_mod_phase_q;
  logic                 r_mod_en, r_done;
  logic                 w_accept, w_up, w_down, w_at_target, w_at_zero;

  assign cmd_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign w_accept    = cmd_valid & cmd_ready;
  assign mod_en      = r_mod_en;
  assign mod_step    = r_mod_step;
  assign mod_phase_q = r_mod_phase_q;
  assign done        = r_done;

  iq_amp_ramp #(
    .AMP_WIDTH (AMP_WIDTH),
    .RAMP_STEP (RAMP_STEP)
  ) u_ramp (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .i_up        (w_up),
    .i_down      (w_down),
    .i_clear     (w_accept),
    .i_target    (r_target),
    .o_amp       (mod_amp),
    .o_at_target (w_at_target),
    .o_at_zero   (w_at_zero)
  );

  // Abort freezes the ramp-up so the ramp-down starts from the amplitude now on the output
  always_comb begin
    w_next = r_state;
    w_up   = 1'b0;
    w_down = 1'b0;
    case (r_state)
      IDLE:      if (w_accept) w_next = RAMP_UP;
      RAMP_UP: begin
        if (abort_in) w_next = RAMP_DOWN;
        else begin
          w_up = 1'b1;
          if (w_at_target) w_next = HOLD;
        end
      end
      HOLD:      if (abort_in || r_hold_cnt <= LEN_W'(1)) w_next = RAMP_DOWN;
      RAMP_DOWN: begin
        w_down = 1'b1;
        if (w_at_zero) w_next = GAP;
      end
      GAP:       if (r_gap_cnt <= LEN_W'(1)) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state       <= IDLE;
      r_target      <= '0;
      r_len         <= '0;
      r_gap         <= '0;
      r_mod_step    <= '0;
      r_mod_phase_q <= '0;
      r_mod_en      <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_mod_en <= (w_next == RAMP_UP) || (w_next == HOLD) || (w_next == RAMP_DOWN);
      r_done   <= (r_state == GAP) && (w_next == IDLE);
      if (w_accept) begin
        r_target      <= cmd_amp;
        r_len         <= cmd_len;
        r_gap         <= cmd_gap;
        r_mod_step    <= cmd_step;
        r_mod_phase_q <= cmd_phase_q;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (r_state == RAMP_UP && w_next == HOLD)       r_hold_cnt <= r_len;
      else if (r_state == HOLD && r_hold_cnt != '0)   r_hold_cnt <= r_hold_cnt - LEN_W'(1);
      if (r_state == RAMP_DOWN && w_next == GAP)      r_gap_cnt  <= r_gap;
      else if (r_state == GAP && r_gap_cnt != '0)     r_gap_cnt  <= r_gap_cnt - LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_iq_burst_ctrl.sv
// Directed bench for iq_burst_ctrl with RAMP_STEP = 64; expected sequences are hand-computed.
module tb_iq_burst_ctrl;

  localparam int ADDR_W    = 10;
  localparam int AMP_WIDTH = 8;
  localparam int LEN_W     = 16;
  localparam int RAMP_STEP = 64;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 cmd_valid, cmd_ready, abort_in;
  logic [ADDR_W-1:0]    cmd_step, cmd_phase_q, mod_step, mod_phase_q;
  logic [AMP_WIDTH-1:0] cmd_amp, mod_amp;
  logic [LEN_W-1:0]     cmd_len, cmd_gap;
  logic                 mod_en, busy, done;

  int errs   = 0;
  int checks = 0;
  int exp_q[$];
  int abort_at = -1;

  iq_burst_ctrl #(
    .ADDR_W (ADDR_W), .AMP_WIDTH (AMP_WIDTH), .LEN_W (LEN_W), .RAMP_STEP (RAMP_STEP)
  ) dut (
    .clk_in (clk_in), .rst_in (rst_in),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_step (cmd_step), .cmd_phase_q (cmd_phase_q), .cmd_amp (cmd_amp),
    .cmd_len (cmd_len), .cmd_gap (cmd_gap), .abort_in (abort_in),
    .mod_en (mod_en), .mod_step (mod_step), .mod_phase_q (mod_phase_q),
    .mod_amp (mod_amp), .busy (busy), .done (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int step, input int phq, input int amp, input int len, input int gap);
    cmd_step    = 10'(step);
    cmd_phase_q = 10'(phq);
    cmd_amp     = 8'(amp);
    cmd_len     = 16'(len);
    cmd_gap     = 16'(gap);
    cmd_valid   = 1'b1;
    chk("ready_before_accept", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Walks the active phase against exp_q, then the gap, then the done cycle
  task automatic run_burst(input string tag, input int ngap, input int step, input int phq);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) abort_in = 1'b1;
      chk($sformatf("%s_en[%0d]", tag, i), 32'(mod_en), 1);
      chk($sformatf("%s_amp[%0d]", tag, i), 32'(mod_amp), 32'(exp_q[i]));
      chk($sformatf("%s_step[%0d]", tag, i), 32'(mod_step), 32'(step));
      chk($sformatf("%s_ready[%0d]", tag, i), 32'(cmd_ready), 0);
      tick();
      abort_in = 1'b0;
    end
    for (int g = 0; g < ngap; g++) begin
      chk($sformatf("%s_gap_en[%0d]", tag, g), 32'(mod_en), 0);
      chk($sformatf("%s_gap_busy[%0d]", tag, g), 32'(busy), 1);
      chk($sformatf("%s_gap_done[%0d]", tag, g), 32'(done), 0);
      chk($sformatf("%s_gap_amp[%0d]", tag, g), 32'(mod_amp), 0);
    tick();
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_done_busy"}, 32'(busy), 0);
    chk({tag, "_done_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_idle_step"}, 32'(mod_step), 32'(step));
    chk({tag, "_idle_phq"}, 32'(mod_phase_q), 32'(phq));
    tick();
    chk({tag, "_done_once"}, 32'(done), 0);
  endtask

  initial begin
    rst_in = 1'b1; cmd_valid = 1'b0; abort_in = 1'b0;
    cmd_step = '0; cmd_phase_q = '0; cmd_amp = '0; cmd_len = '0; cmd_gap = '0;
    repeat (2) tick();
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_en", 32'(mod_en), 0);
    chk("rst_amp", 32'(mod_amp), 0);
    chk("rst_step", 32'(mod_step), 0);
    chk("rst_phq", 32'(mod_phase_q), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_in = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 0);

    // Basic burst: 4 ramp-up, 4 hold, 5 ramp-down (starts at 255), 3 gap
    send(5, 3, 255, 4, 3);
    exp_q = '{0, 64, 128, 192, 255, 255, 255, 255, 255, 191, 127, 63, 0};
    run_burst("basic", 3, 5, 3);

    // Zero amplitude, zero len/gap: one cycle in each state
    send(7, 1, 0, 0, 0);
    exp_q = '{0, 0, 0};
    run_burst("zero", 1, 7, 1);

    // Abort in second HOLD cycle: ramp-down from 200
    send(2, 4, 200, 10, 2);
    abort_at = 5;
    exp_q = '{0, 64, 128, 192, 200, 200, 200, 136, 72, 8, 0};
    run_burst("abort_hold", 2, 2, 4);

    // Abort colliding with RAMP_UP->HOLD: no final increment, ramp-down from 192
    send(3, 5, 200, 10, 1);
    abort_at = 3;
    exp_q = '{0, 64, 128, 192, 192, 128, 64, 0};
    run_burst("abort_ru", 1, 3, 5);
    abort_at = -1;

    // Saturation at target on the way up, clamp at zero on the way down
    send(1, 1, 250, 1, 1);
    exp_q = '{0, 64, 128, 192, 250, 250, 186, 122, 58, 0};
    run_burst("sat", 1, 1, 1);

    // Back-to-back with cmd_valid held high
    cmd_step = 10'd8; cmd_phase_q = 10'd0; cmd_amp = 8'd0; cmd_len = 16'd0; cmd_gap = 16'd0;
    cmd_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_a_ready[%0d]", i), 32'(cmd_ready), 0);
      chk($sformatf("b2b_a_busy[%0d]", i), 32'(busy), 1);
      tick();
    end
    chk("b2b_a_done", 32'(done), 1);
    chk("b2b_a_done_ready", 32'(cmd_ready), 1);
    cmd_step = 10'd9;
    tick();
    chk("b2b_b_accepted_en", 32'(mod_en), 1);
    chk("b2b_b_step", 32'(mod_step), 9);
    chk("b2b_b_ready", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    repeat (4) tick();
    chk("b2b_b_done", 32'(done), 1);
    tick();

    // Asynchronous reset during HOLD
    send(6, 2, 64, 20, 1);
    tick();
    chk("rst_mid_in_hold_en", 32'(mod_en), 1);
    chk("rst_mid_in_hold_amp", 32'(mod_amp), 64);
    #3;
    rst_in = 1'b1;
    #1;
    chk("arst_en", 32'(mod_en), 0);
    chk("arst_amp", 32'(mod_amp), 0);
    chk("arst_step", 32'(mod_step), 0);
    chk("arst_phq", 32'(mod_phase_q), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(cmd_ready), 1);
    chk("arst_done", 32'(done), 0);
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_arst_done[%0d]", i), 32'(done), 0);
      chk($sformatf("post_arst_ready[%0d]", i), 32'(cmd_ready), 1);
      chk($sformatf("post_arst_busy[%0d]", i), 32'(busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
